// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited requests to instruction memory, an in-order
// response buffer toward decode, and redirects that discard responses still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];

  logic [CNT_W:0]   credits_used;
  logic             gnt_ok;
  logic             rsp_ok;
  logic             redirect_ok;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [31:0]      redirect_aligned;

  // A request consumes a credit until its response lands in the buffer, so
  // buffered entries plus requests in flight can never exceed the buffer size.
  assign credits_used     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o       = (state == FETCH) && (credits_used < DEPTH_LIM);
  assign imem_addr_o      = fetch_pc;

  assign gnt_ok           = imem_req_o & imem_gnt_i;
  assign rsp_ok           = imem_rvalid_i & (outstanding != '0);
  assign redirect_ok      = redirect_i & (state != IDLE);
  assign push             = rsp_ok & (state == FETCH) & ~redirect_ok;
  assign pop              = valid_o & ready_i & ~redirect_ok;
  assign outstanding_nxt  = outstanding + CNT_W'(gnt_ok) - CNT_W'(rsp_ok);
  assign redirect_aligned = redirect_pc_i & ~32'h0000_0003;

  assign valid_o  = (count != '0);
  assign instr_o  = valid_o ? buf_instr[head] : '0;
  assign pc_o     = valid_o ? buf_pc[head]    : '0;
  assign opcode_o = instr_o[6:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_ok) begin
        // Requests granted before or during this cycle still return data; count
        // them so FLUSH knows how many responses belong to the old path.
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop_cnt <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? FLUSH : FETCH;
      end else begin
        if (gnt_ok) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          tail    <= tail + PTR_W'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) head <= head + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        unique case (state)
          IDLE:  state <= FETCH;
          FETCH: state <= FETCH;
          FLUSH: begin
            if (rsp_ok) begin
              drop_cnt <= drop_cnt - CNT_W'(1);
              if (drop_cnt == CNT_W'(1)) state <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; count gates every read, and
  // the outputs are forced to zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr[tail] <= imem_rdata_i;
      buf_pc[tail]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases queue expected PCs,
// a memory model answers grants, and a monitor checks every decode handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;

  logic        gnt_en;
  logic        rsp_en;
  logic [31:0] exp_q  [$];
  logic [31:0] pend_q [$];
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Let decode accept until every queued expectation has been consumed.
  task automatic drain(input int budget);
    int n;
    n = 0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    ready_i = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Memory model: grants follow gnt_en; responses return in order, at the
  // earliest one cycle after the grant, whenever rsp_en allows.
  initial begin : imem_model
    logic        gnt_fire;
    logic        rsp_fire;
    logic [31:0] gnt_addr;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      gnt_fire = imem_req_o && imem_gnt_i;
      gnt_addr = imem_addr_o;
      rsp_fire = imem_rvalid_i;
      @(posedge clk_i);
      #2;
      if (rsp_fire && pend_q.size() != 0) void'(pend_q.pop_front());
      if (gnt_fire) pend_q.push_back(gnt_addr);
      imem_gnt_i = gnt_en;
      if (rsp_en && pend_q.size() != 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = imem_word(pend_q[0]);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  initial begin : monitor
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    forever begin
      @(negedge clk_i);
      if (rst_ni && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h instr %h, expected no output", pc_o, instr_o);
        end else begin
          exp_pc    = exp_q.pop_front();
          exp_instr = imem_word(exp_pc);
          check("pop_pc", pc_o, exp_pc);
          check("pop_instr", instr_o, exp_instr);
          check("pop_opcode", 32'(opcode_o), {25'd0, exp_instr[6:0]});
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst_ni        = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ready_i       = 1'b0;
    gnt_en        = 1'b1;
    rsp_en        = 1'b1;
    #2 rst_ni = 1'b0;
    step(2);

    // Reset state
    @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_opcode", 32'(opcode_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_addr", imem_addr_o, RST_PC);
    step(1);

    // Streaming fetch from RESET_PC, including the wrap through zero
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    exp_q   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    @(negedge clk_i);
    check("idle_no_req", 32'(imem_req_o), 32'd0);
    @(negedge clk_i);
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, RST_PC);
    step(1);
    drain(60);

    // Decode stall: buffer fills, requests stop, head holds
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (i >= 5) begin
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_pc", pc_o, 32'h10);
        check("stall_instr", instr_o, imem_word(32'h10));
      end
      step(1);
    end
    exp_q = '{32'h10, 32'h14};
    drain(20);

    // Redirect with two requests in flight
    step(5);
    rsp_en = 1'b0;
    exp_q  = '{32'h18, 32'h1C};
    drain(20);
    step(4);
    @(negedge clk_i);
    check("credits_full_req", 32'(imem_req_o), 32'd0);
    step(1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    step(1);
    redirect_i = 1'b0;
    rsp_en     = 1'b1;
    ready_i    = 1'b1;
    exp_q      = '{32'h100, 32'h104};
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!imem_req_o && n < 20);
    check("flush_req_seen", 32'(imem_req_o), 32'd1);
    check("flush_addr", imem_addr_o, 32'h100);
    step(1);
    drain(20);

    // Redirect coinciding with a pop and a response
    step(5);
    rsp_en = 1'b0;
    exp_q  = '{32'h108};
    drain(20);
    step(3);
    @(negedge clk_i);
    check("pre_redir_req", 32'(imem_req_o), 32'd0);
    check("pre_redir_pc", pc_o, 32'h10C);
    step(1);
    exp_q         = '{32'h10C};
    ready_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    rsp_en        = 1'b1;
    step(1);
    redirect_i = 1'b0;
    ready_i    = 1'b0;
    @(negedge clk_i);
    check("redir_pop_consumed", 32'(exp_q.size()), 32'd0);
    check("redir_empty", 32'(valid_o), 32'd0);
    check("redir_req", 32'(imem_req_o), 32'd1);
    check("redir_addr", imem_addr_o, 32'h200);
    step(1);
    exp_q = '{32'h200, 32'h204};
    drain(20);

    // Reset pulse with two requests in flight
    step(5);
    rsp_en = 1'b0;
    exp_q  = '{32'h208, 32'h20C};
    drain(20);
    step(4);
    gnt_en = 1'b0;
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("async_rst_addr", imem_addr_o, RST_PC);
    check("async_rst_req", 32'(imem_req_o), 32'd0);
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_pc", pc_o, 32'd0);
    step(1);
    rst_ni = 1'b1;
    rsp_en = 1'b1;
    step(4);
    @(negedge clk_i);
    check("restart_valid", 32'(valid_o), 32'd0);
    check("restart_req", 32'(imem_req_o), 32'd1);
    check("restart_addr", imem_addr_o, RST_PC);
    step(1);
    gnt_en = 1'b1;
    exp_q  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    drain(40);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
